// File: rtl/cg_pkg.sv
// Shared types and helpers for the conjugate-gradient control path.
package cg_pkg;

    localparam int unsigned ELEMENT_WIDTH = 32;

    typedef enum logic [3:0] {
        IDLE,
        RR,
        AP,
        ALPHA,
        XR,
        RNEW,
        CHECK,
        BETA,
        PUPD,
        FINISH
    } cg_state_t;

    // rs values are non-negative floats, so a raw unsigned compare orders them;
    // a set sign bit on the left operand never counts as "less than".
    function automatic logic fp_nonneg_lt(input logic [ELEMENT_WIDTH-1:0] a,
                                          input logic [ELEMENT_WIDTH-1:0] b);
        return !a[ELEMENT_WIDTH-1] && (a < b);
    endfunction

endpackage

// File: rtl/cg_done_join.sv
// Sticky completion join: all_done fires on the cycle the last outstanding done arrives.
module cg_done_join #(
    parameter int unsigned N_INPUTS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_INPUTS-1:0] done_in,
    output logic                all_done
);

    logic [N_INPUTS-1:0] seen;
    logic [N_INPUTS-1:0] hit;

    assign hit      = seen | (enable ? done_in : '0);
    assign all_done = enable && (&hit);

    // Flags clear on the same edge the join completes, ready for the next iteration.
    always_ff @(posedge clk) begin
        if (reset)
            seen <= '0;
        else if (all_done)
            seen <= '0;
        else
            seen <= hit;
    end

endmodule

// File: rtl/cg_iteration_sequencer.sv
// CG iteration controller: sequences the arithmetic units, tracks rs_old/rs_new,
// applies tolerance and iteration limit.
module cg_iteration_sequencer
    import cg_pkg::*;
#(
    parameter int unsigned ELEMENT_WIDTH = cg_pkg::ELEMENT_WIDTH,
    parameter int unsigned ITER_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [ELEMENT_WIDTH-1:0] tolerance,
    input  logic [ITER_WIDTH-1:0]    max_iter,
    output logic                     rr_start,
    output logic                     ap_start,
    output logic                     alpha_start,
    output logic                     xr_start,
    output logic                     rnew_start,
    output logic                     beta_start,
    output logic                     p_start,
    input  logic                     rr_done,
    input  logic                     pap_done,
    input  logic                     alpha_done,
    input  logic                     x_done,
    input  logic                     r_done,
    input  logic                     rnew_done,
    input  logic                     beta_done,
    input  logic                     p_done,
    input  logic [ELEMENT_WIDTH-1:0] rr_result,
    input  logic [ELEMENT_WIDTH-1:0] rnew_result,
    output logic [ELEMENT_WIDTH-1:0] rs_old,
    output logic [ELEMENT_WIDTH-1:0] rs_new,
    output logic [ITER_WIDTH-1:0]    iter_count,
    output logic                     busy,
    output logic                     done,
    output logic                     converged
);

    cg_state_t state_q, state_d;

    logic [ELEMENT_WIDTH-1:0] tol_q;
    logic [ITER_WIDTH-1:0]    max_q;
    logic rr_start_d, ap_start_d, alpha_start_d, xr_start_d;
    logic rnew_start_d, beta_start_d, p_start_d, done_d;
    logic rr_ok, pap_ok, alpha_ok, rnew_ok, beta_ok, p_ok, xr_ok;

    // A done coinciding with its own start pulse belongs to an earlier request.
    assign rr_ok    = rr_done    && !rr_start;
    assign pap_ok   = pap_done   && !ap_start;
    assign alpha_ok = alpha_done && !alpha_start;
    assign rnew_ok  = rnew_done  && !rnew_start;
    assign beta_ok  = beta_done  && !beta_start;
    assign p_ok     = p_done     && !p_start;

    cg_done_join #(.N_INPUTS(2)) u_xr_join (
        .clk      (clk),
        .reset    (reset),
        .enable   ((state_q == XR) && !xr_start),
        .done_in  ({x_done, r_done}),
        .all_done (xr_ok)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (go) state_d = RR;
            RR:     if (rr_ok) begin
                        if (fp_nonneg_lt(rr_result, tol_q) || (max_q == '0))
                            state_d = FINISH;
                        else
                            state_d = AP;
                    end
            AP:     if (pap_ok)   state_d = ALPHA;
            ALPHA:  if (alpha_ok) state_d = XR;
            XR:     if (xr_ok)    state_d = RNEW;
            RNEW:   if (rnew_ok)  state_d = CHECK;
            CHECK:  if (fp_nonneg_lt(rs_new, tol_q) || (iter_count == max_q))
                        state_d = FINISH;
                    else
                        state_d = BETA;
            BETA:   if (beta_ok)  state_d = PUPD;
            PUPD:   if (p_ok)     state_d = AP;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Start pulses are the registered "entering this state" condition.
    always_comb begin
        rr_start_d    = (state_d == RR)    && (state_q != RR);
        ap_start_d    = (state_d == AP)    && (state_q != AP);
        alpha_start_d = (state_d == ALPHA) && (state_q != ALPHA);
        xr_start_d    = (state_d == XR)    && (state_q != XR);
        rnew_start_d  = (state_d == RNEW)  && (state_q != RNEW);
        beta_start_d  = (state_d == BETA)  && (state_q != BETA);
        p_start_d     = (state_d == PUPD)  && (state_q != PUPD);
        done_d        = (state_q == FINISH);
    end

    // busy covers FINISH; the registered done lands on the first IDLE cycle.
    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_start    <= 1'b0;
            ap_start    <= 1'b0;
            alpha_start <= 1'b0;
            xr_start    <= 1'b0;
            rnew_start  <= 1'b0;
            beta_start  <= 1'b0;
            p_start     <= 1'b0;
            done        <= 1'b0;
        end else begin
            rr_start    <= rr_start_d;
            ap_start    <= ap_start_d;
            alpha_start <= alpha_start_d;
            xr_start    <= xr_start_d;
            rnew_start  <= rnew_start_d;
            beta_start  <= beta_start_d;
            p_start     <= p_start_d;
            done        <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tol_q      <= '0;
            max_q      <= '0;
            rs_old     <= '0;
            rs_new     <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (go) begin
                    tol_q      <= tolerance;
                    max_q      <= max_iter;
                    iter_count <= '0;
                    converged  <= 1'b0;
                end
                RR: if (rr_ok) begin
                    rs_old <= rr_result;
                    if (fp_nonneg_lt(rr_result, tol_q))
                        converged <= 1'b1;
                end
                RNEW: if (rnew_ok) begin
                    rs_new <= rnew_result;
                    if (iter_count != '1)
                        iter_count <= iter_count + ITER_WIDTH'(1);
                end
                CHECK: if (fp_nonneg_lt(rs_new, tol_q))
                    converged <= 1'b1;
                PUPD: if (p_ok)
                    rs_old <= rs_new;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Directed self-checking bench for cg_iteration_sequencer.
module tb_cg_iteration_sequencer;

    logic        clk = 1'b0;
    logic        reset, go;
    logic [31:0] tolerance;
    logic [15:0] max_iter;
    logic rr_start, ap_start, alpha_start, xr_start, rnew_start, beta_start, p_start;
    logic rr_done, pap_done, alpha_done, x_done, r_done, rnew_done, beta_done, p_done;
    logic [31:0] rr_result, rnew_result, rs_old, rs_new;
    logic [15:0] iter_count;
    logic        busy, done, converged;

    int errors = 0;
    int checks = 0;
    int n_ap = 0, n_alpha = 0, n_xr = 0, n_rnew = 0, n_beta = 0, n_p = 0, n_done = 0;
    int b_ap, b_alpha, b_xr, b_rnew, b_beta, b_p, b_done;

    localparam logic [31:0] TOL = 32'h283424DC;
    localparam logic [31:0] ONE = 32'h3F800000;

    cg_iteration_sequencer #(.ELEMENT_WIDTH(32), .ITER_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .go(go), .tolerance(tolerance), .max_iter(max_iter),
        .rr_start(rr_start), .ap_start(ap_start), .alpha_start(alpha_start),
        .xr_start(xr_start), .rnew_start(rnew_start), .beta_start(beta_start),
        .p_start(p_start), .rr_done(rr_done), .pap_done(pap_done),
        .alpha_done(alpha_done), .x_done(x_done), .r_done(r_done),
        .rnew_done(rnew_done), .beta_done(beta_done), .p_done(p_done),
        .rr_result(rr_result), .rnew_result(rnew_result), .rs_old(rs_old),
        .rs_new(rs_new), .iter_count(iter_count), .busy(busy), .done(done),
        .converged(converged)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ap_start)    n_ap++;
        if (alpha_start) n_alpha++;
        if (xr_start)    n_xr++;
        if (rnew_start)  n_rnew++;
        if (beta_start)  n_beta++;
        if (p_start)     n_p++;
        if (done)        n_done++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic start_of(input int w);
        case (w)
            0: return rr_start;
            1: return ap_start;
            2: return alpha_start;
            3: return xr_start;
            4: return rnew_start;
            5: return beta_start;
            default: return p_start;
        endcase
    endfunction

    task automatic set_done(input int w, input logic v);
        case (w)
            0: rr_done = v;
            1: pap_done = v;
            2: alpha_done = v;
            3: begin x_done = v; r_done = v; end
            4: rnew_done = v;
            5: beta_done = v;
            default: p_done = v;
        endcase
    endtask

    task automatic await_start(input int w, input string tag);
        int n = 0;
        while (!start_of(w) && n < 40) begin
            tick();
            n++;
        end
        check(tag, start_of(w), 1);
    endtask

    task automatic respond(input int w, input string tag);
        await_start(w, tag);
        tick();
        set_done(w, 1'b1);
        tick();
        set_done(w, 1'b0);
    endtask

    task automatic await_done(input string tag);
        int n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check(tag, done, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic snapshot();
        b_ap = n_ap; b_alpha = n_alpha; b_xr = n_xr; b_rnew = n_rnew;
        b_beta = n_beta; b_p = n_p; b_done = n_done;
    endtask

    // One CG iteration from the AP start up to the CHECK cycle (plus BETA/PUPD unless last).
    task automatic do_iter(input logic [31:0] val, input int xr_mode, input bit last, input bit stray);
        if (stray) begin
            await_start(1, "stray_ap_start");
            alpha_done = 1'b1;
            tick();
            alpha_done = 1'b0;
            tick();
            pap_done = 1'b1;
            tick();
            pap_done = 1'b0;
            check("stray_alpha_start", alpha_start, 1);
            alpha_done = 1'b1;
            tick();
            alpha_done = 1'b0;
            check("stray_same_cycle_ignored", xr_start, 0);
            tick();
            tick();
            check("stray_still_waiting", xr_start, 0);
            alpha_done = 1'b1;
            tick();
            alpha_done = 1'b0;
            check("stray_real_alpha_done", xr_start, 1);
        end else begin
            respond(1, "ap_start");
            respond(2, "alpha_start");
        end
        await_start(3, "xr_start");
        tick();
        case (xr_mode)
            0: begin
                r_done = 1'b1; tick(); r_done = 1'b0;
                check("xr_r_first_wait", rnew_start, 0);
                x_done = 1'b1; tick(); x_done = 1'b0;
                check("xr_r_then_x", rnew_start, 1);
            end
            1: begin
                x_done = 1'b1; tick(); x_done = 1'b0;
                check("xr_x_first_wait", rnew_start, 0);
                r_done = 1'b1; tick(); r_done = 1'b0;
                check("xr_x_then_r", rnew_start, 1);
            end
            default: begin
                x_done = 1'b1; r_done = 1'b1; tick(); x_done = 1'b0; r_done = 1'b0;
                check("xr_same_cycle", rnew_start, 1);
            end
        endcase
        rnew_result = val;
        tick();
        rnew_done = 1'b1;
        tick();
        rnew_done = 1'b0;
        if (!last) begin
            respond(5, "beta_start");
            respond(6, "p_start");
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; tolerance = '0; max_iter = '0;
        rr_done = 0; pap_done = 0; alpha_done = 0; x_done = 0; r_done = 0;
        rnew_done = 0; beta_done = 0; p_done = 0; rr_result = '0; rnew_result = '0;
        tick();
        tick();
        check("reset_outputs", {rr_start, ap_start, alpha_start, xr_start, rnew_start,
                                beta_start, p_start, busy, done, converged}, 0);
        check("reset_rs", {rs_old, rs_new}, 0);
        check("reset_iter", iter_count, 0);

        // go coinciding with reset is dropped
        go = 1'b1;
        tick();
        reset = 1'b0; go = 1'b0;
        tick();
        check("go_during_reset_busy", busy, 0);
        check("go_during_reset_rr", rr_start, 0);

        // zero initial residual
        snapshot();
        tolerance = TOL; max_iter = 16'd5; rr_result = 32'h0;
        go = 1'b1;
        check("busy_before_go_edge", busy, 0);
        tick();
        go = 1'b0;
        check("busy_after_go", busy, 1);
        check("zero_rr_start", rr_start, 1);
        tick();
        rr_done = 1'b1;
        tick();
        rr_done = 1'b0;
        check("zero_done_early", done, 0);
        check("zero_busy_finish", busy, 1);
        tick();
        check("zero_done_latency", done, 1);
        check("zero_busy_low", busy, 0);
        check("zero_converged", converged, 1);
        check("zero_iter", iter_count, 0);
        check("zero_no_ap", n_ap - b_ap, 0);
        tick();
        check("done_one_cycle", done, 0);

        // iteration limit with all three XR orderings
        snapshot();
        max_iter = 16'd3; rr_result = ONE;
        go = 1'b1; tick(); go = 1'b0;
        respond(0, "lim_rr_start");
        do_iter(ONE, 0, 0, 0);
        check("lim_iter_1", iter_count, 1);
        do_iter(ONE, 1, 0, 0);
        do_iter(ONE, 2, 1, 0);
        await_done("lim_done");
        check("lim_converged", converged, 0);
        check("lim_iter", iter_count, 3);
        check("lim_ap", n_ap - b_ap, 3);
        check("lim_alpha", n_alpha - b_alpha, 3);
        check("lim_xr", n_xr - b_xr, 3);
        check("lim_rnew", n_rnew - b_rnew, 3);
        check("lim_beta", n_beta - b_beta, 2);
        check("lim_p", n_p - b_p, 2);

        // convergence on iteration 2, with stray alpha_done in the first
        snapshot();
        max_iter = 16'd10; rr_result = ONE;
        go = 1'b1; tick(); go = 1'b0;
        respond(0, "conv_rr_start");
        do_iter(ONE, 2, 0, 1);
        check("stray_alpha_count", n_alpha - b_alpha, 1);
        do_iter(32'h28000000, 2, 1, 0);
        await_done("conv_done");
        check("conv_converged", converged, 1);
        check("conv_iter", iter_count, 2);
        check("conv_rs_old", rs_old, ONE);
        check("conv_rs_new", rs_new, 32'h28000000);
        check("conv_beta", n_beta - b_beta, 1);

        // max_iter of zero: no iterations
        snapshot();
        max_iter = 16'd0; rr_result = ONE;
        go = 1'b1; tick(); go = 1'b0;
        respond(0, "zero_lim_rr_start");
        await_done("zero_lim_done");
        check("zero_lim_converged", converged, 0);
        check("zero_lim_no_ap", n_ap - b_ap, 0);
        check("zero_lim_rs_old", rs_old, ONE);

        // reset in BETA
        max_iter = 16'd5;
        go = 1'b1; tick(); go = 1'b0;
        respond(0, "rst_rr_start");
        do_iter(ONE, 2, 1, 0);
        await_start(5, "rst_beta_start");
        tick();
        snapshot();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_outputs", {rr_start, ap_start, alpha_start, xr_start, rnew_start,
                              beta_start, p_start, busy, done, converged}, 0);
        check("rst_regs", {rs_old, rs_new, iter_count}, 0);
        tick();
        tick();
        check("rst_no_done", n_done - b_done, 0);

        // full solve after reset
        snapshot();
        max_iter = 16'd1;
        go = 1'b1; tick(); go = 1'b0;
        respond(0, "post_rr_start");
        do_iter(ONE, 0, 1, 0);
        await_done("post_done");
        check("post_converged", converged, 0);
        check("post_iter", iter_count, 1);
        check("post_no_beta", n_beta - b_beta, 0);
        check("post_rs_new", rs_new, ONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cg_iteration_sequencer.md
# cg_iteration_sequencer

Parametrised iteration controller for the conjugate-gradient datapath: it sequences the r·r, A·p, p·Ap, alpha-divide, x/r update, r_new·r_new, beta-divide and p-update units through complete CG iterations. It holds rs_old/rs_new, applies a runtime tolerance and an iteration limit, and clears all per-iteration state at each iteration boundary. It sits between the top-level solver control and the arithmetic units, which it drives through one-cycle start pulses and sticky done handshakes.

## Interface
- ELEMENT_WIDTH, 32: width of scalar results (IEEE-754 single).
- ITER_WIDTH, 16: width of the iteration counter and limit.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- go  in  1  one-cycle pulse; starts a solve when idle. Ignored while busy.
- tolerance  in  ELEMENT_WIDTH  convergence threshold on rs_new; sampled on accepted go.
- max_iter  in  ITER_WIDTH  iteration limit; sampled on accepted go; 0 means no iterations.
- rr_start, ap_start, alpha_start, xr_start, rnew_start, beta_start, p_start  out  1 each  one-cycle unit start pulses.
- rr_done, pap_done, alpha_done, x_done, r_done, rnew_done, beta_done, p_done  in  1 each  unit completion pulses.
- rr_result, rnew_result  in  ELEMENT_WIDTH  dot-product results, valid while the matching done is high.
- rs_old, rs_new  out  ELEMENT_WIDTH  registered residual norms; beta divide uses rs_new/rs_old.
- iter_count  out  ITER_WIDTH  completed iterations.
- busy  out  1  high from accepted go until done.
- done  out  1  one-cycle pulse at end of solve.
- converged  out  1  status of last solve: 1 = tolerance met, 0 = limit reached; held until the next go.

## Operation
- States: IDLE, RR, AP, ALPHA, XR, RNEW, CHECK, BETA, PUPD, FINISH.
- IDLE: on go, latch tolerance and max_iter, clear iter_count and converged, enter RR.
- RR: wait for rr_done; rs_old <= rr_result. If rr_result < tolerance, converged <= 1 and enter FINISH. Else if max_iter == 0, enter FINISH. Else enter AP.
- AP: ap_start; wait pap_done (pap_done implies mXv complete); enter ALPHA.
- ALPHA: alpha_start; wait alpha_done; enter XR.
- XR: xr_start drives both x and r update units. Sticky flags x_seen and r_seen record x_done and r_done in either order or the same cycle. Enter RNEW when both are set; both flags clear on exit.
- RNEW: rnew_start; wait rnew_done; rs_new <= rnew_result; iter_count += 1; enter CHECK.
- CHECK (1 cycle): if rs_new < tolerance, converged <= 1 and enter FINISH. Else if iter_count == max_iter, enter FINISH. Else enter BETA.
- BETA: beta_start; wait beta_done; enter PUPD.
- PUPD: p_start; wait p_done; rs_old <= rs_new; enter AP.
- FINISH: done pulse; enter IDLE.
- Compare rule: rs values are non-negative floats, so "<" is an unsigned compare of the bit patterns. A sign bit set on rs is treated as not converged.
- A done input received in a state that is not waiting for it is ignored; it is not remembered.

## Timing
- Reset: state IDLE; all outputs 0; rs_old, rs_new, iter_count, and the x/r sticky flags are 0.
- Reset mid-solve: returns to IDLE on the next edge. No done pulse is issued. Any unit start already issued is not cancelled.
- Start pulses are registered and high for exactly the first cycle of their state.
- A done input is accepted from the cycle after the start pulse onward. A done in the same cycle as start is ignored.
- Minimum latency from a done input to the next unit's start pulse is 1 cycle (next state entered on the done edge, start high in its first cycle). CHECK adds 1 cycle.
- busy rises the cycle after go. It falls together with the done pulse, so done and busy never overlap.
- go in the same cycle as reset is ignored.
- iter_count saturates at all-ones. It cannot exceed max_iter.

## Structure
- Shared package cg_pkg: state enum cg_state_t, ELEMENT_WIDTH default, and a function fp_nonneg_lt(a, b) implementing the compare rule; the same function is used by future tolerance logic elsewhere.
- One natural sub-module, cg_done_join, implements the two-input sticky completion join for XR. It is parametrised on input count for later multi-cluster use.
- The rest is a single FSM plus datapath registers in cg_iteration_sequencer.

## Test plan
- Zero initial residual: go, rr_result=32'h00000000, tolerance=32'h283424DC -> no ap_start; done 2 cycles after rr_done; converged=1; iter_count=0.
- Limit reached: max_iter=3, rnew_result always 32'h3F800000 -> exactly 3 each of ap/alpha/xr/rnew starts and 2 each of beta_start and p_start; done with converged=0 and iter_count=3.
- Convergence on 2nd iteration: rnew_result 32'h3F800000 then 32'h28000000, tolerance=32'h283424DC -> converged=1, iter_count=2, rs_old=32'h3F800000 at done.
- XR join ordering: r_done before x_done, then x_done before r_done, then both in the same cycle -> rnew_start exactly once per iteration, 1 cycle after the later done.
- Stray/early done: alpha_done asserted in the same cycle as alpha_start and again during AP -> ignored; the FSM waits for the real alpha_done.
- Reset mid-solve: assert reset during BETA -> next cycle IDLE, busy=0, all outputs 0, no done pulse; a following go runs a full solve correctly.
